// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: next-PC unit op codes, reset PC
// and the fetch FSM state encoding.
package fetch_sequencer_pkg;

  localparam logic [1:0] NPC_ADD4     = 2'b00;
  localparam logic [1:0] NPC_ADD4_IMM = 2'b01;
  localparam logic [1:0] NPC_IMM      = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_SQUASH = 2'd3;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the external next-PC unit,
// fetches words over req/ack and hands them to decode over valid/ready.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redir_valid,
  input  logic        redir_kind,
  input  logic [31:0] redir_base,
  input  logic [31:0] redir_imm,
  output logic [1:0]  npc_op,
  output logic [31:0] npc_i,
  output logic [31:0] npc_imm,
  input  logic [31:0] npc_in
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;

  // A redirect takes over the next-PC unit; otherwise it computes pc+4.
  always_comb begin
    npc_op  = NPC_ADD4;
    npc_i   = pc;
    npc_imm = 32'd0;
    if (redir_valid) begin
      npc_op  = redir_kind ? NPC_IMM : NPC_ADD4_IMM;
      npc_i   = redir_base;
      npc_imm = redir_imm;
    end
  end

  assign imem_req  = (state == ST_FETCH) || (state == ST_SQUASH);
  assign imem_addr = req_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_START;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'd0;
      if_pc    <= 32'd0;
    end else if (redir_valid) begin
      pc       <= npc_in;
      if_valid <= 1'b0;
      // An outstanding request cannot be withdrawn; wait out its ack in SQUASH.
      if (imem_req && !imem_ack) begin
        state <= ST_SQUASH;
      end else begin
        state    <= ST_FETCH;
        req_addr <= npc_in;
      end
    end else begin
      case (state)
        ST_START: begin
          state    <= ST_FETCH;
          req_addr <= pc;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            if_instr <= imem_rdata;
            if_pc    <= req_addr;
            if_valid <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (if_valid && if_ready) begin
            pc       <= npc_in;
            req_addr <= npc_in;
            if_valid <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        default: begin
          // Stale response from before the redirect: drop it and fetch the target.
          if (imem_ack) begin
            req_addr <= pc;
            state    <= ST_FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Owns the program counter and sequences the existing next-PC adder unit (npc op/operand ports) through instruction fetch. Issues word fetches to instruction memory over a req/ack handshake and presents each fetched instruction to decode over valid/ready. Applies branch/jump redirects from execute, squashing any in-flight or held fetch. Sits between the PC/next-PC datapath, instruction memory and decode in the multi-cycle CPU.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset (first fetch address)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req high
- imem_ack  in  1  one-cycle pulse, completes request; imem_rdata valid same cycle
- imem_rdata  in  32  fetched instruction word
- if_valid  out  1  instruction held for decode
- if_ready  in  1  decode accepts when if_valid & if_ready
- if_instr  out  32  held instruction
- if_pc  out  32  address of held instruction
- redir_valid  in  1  one-cycle redirect pulse from execute
- redir_kind  in  1  0 = relative (base+4+imm), 1 = absolute (imm)
- redir_base  in  32  PC of the redirecting instruction
- redir_imm  in  32  sign-extended, pre-shifted offset or absolute target
- npc_op  out  2  op to next-PC unit: 00 +4, 01 +4+imm, 10 imm
- npc_i  out  32  base operand to next-PC unit
- npc_imm  out  32  immediate operand to next-PC unit
- npc_in  in  32  next-PC unit result (combinational from npc_op/npc_i/npc_imm)

## Operation
- Registers: pc, req_addr, if_instr, if_pc, if_valid, state ∈ {START, FETCH, HOLD, SQUASH}.
- npc drive (combinational): redir_valid → npc_op = redir_kind ? 10 : 01, npc_i = redir_base, npc_imm = redir_imm; else npc_op = 00, npc_i = pc, npc_imm = 0.
- imem_req = (state == FETCH || state == SQUASH); imem_addr = req_addr.
- START: → FETCH; req_addr <= pc.
- FETCH, ack, no redirect: if_instr <= imem_rdata, if_pc <= req_addr, if_valid <= 1, → HOLD.
- HOLD, accept (if_valid & if_ready), no redirect: pc <= npc_in (pc+4), req_addr <= npc_in, if_valid <= 0, → FETCH.
- HOLD, no accept: all held, if_instr/if_pc stable.
- Redirect (any state): pc <= npc_in, if_valid <= 0; next state:
  - START/HOLD: → FETCH, req_addr <= npc_in (held instruction dropped; if accepted same cycle, the handshake completes and the target still wins).
  - FETCH with ack same cycle: response discarded, → FETCH, req_addr <= npc_in.
  - FETCH without ack: → SQUASH; req_addr unchanged (request cannot be aborted).
  - SQUASH: stays SQUASH (pc takes latest target).
- SQUASH, ack, no redirect: data discarded, req_addr <= pc, → FETCH.
- Arithmetic is 32-bit wrap-around (done in next-PC unit); target bits [1:0] passed unchanged, not checked.

## Timing
- Reset values: pc = RESET_PC, req_addr = RESET_PC, state = START, imem_req = 0, if_valid = 0, if_instr = 0, if_pc = 0.
- First imem_req high one cycle after reset deasserts, addr RESET_PC.
- ack in cycle n → if_valid high in n+1; accept in cycle m → imem_req with pc+4 in m+1.
- Peak throughput with 1-cycle ack and ready always high: one instruction per 2 cycles.
- Redirect in cycle r → pc = target from r+1; target fetch addressed in r+1 (START/HOLD/FETCH+ack) or the cycle after the outstanding ack (SQUASH).
- imem_req never drops and imem_addr never changes before ack.
- Reset mid-operation: any state returns to START next edge; outstanding ack after reset ignored (START does not sample ack).

## Structure
- Shared package: npc_op encodings (NPC_ADD4 = 00, NPC_ADD4_IMM = 01, NPC_IMM = 10), RESET_PC default, state encoding.
- Single flat module; next-PC unit is instantiated by the parent and wired to npc_* ports. No sub-module.

## Test plan
- Reset, ack 1 cycle after each req, ready high → imem_addr sequence 0x3000, 0x3004, 0x3008; if_pc matches; if_valid every 2nd cycle.
- ack delayed 3 cycles, if_ready low 4 cycles → imem_addr stable during wait; if_instr/if_pc held until accept; no duplicate fetch.
- HOLD at if_pc 0x3010, redirect relative base 0x300C imm 0x20 → held instr dropped; next imem_addr 0x3030.
- Redirect absolute imm 0x3400 while FETCH outstanding at 0x3008, ack 2 cycles later → response discarded, if_valid stays 0; next imem_addr 0x3400.
- Two redirects during SQUASH (0x3100 then 0x3200) → fetch goes to 0x3200 only.
- reset asserted in FETCH with ack same cycle → if_valid 0, next fetch at 0x3000, pending data never appears on if_instr.
